// File: rtl/psum_acc_pkg.sv
// Shared types and constants for the partial-sum accumulator slice.
// Optional build macro PSUM_ACC_SAT_EN selects saturating lane adds.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    localparam int PSUM_W_DEF = 32;

    localparam logic signed [PSUM_W_DEF-1:0] PSUM_MAX = {1'b0, {(PSUM_W_DEF-1){1'b1}}};
    localparam logic signed [PSUM_W_DEF-1:0] PSUM_MIN = {1'b1, {(PSUM_W_DEF-1){1'b0}}};

endpackage

// File: rtl/psum_lane_add.sv
// One psum lane: passes the new value through on the first pass, otherwise adds.
// Build macro PSUM_ACC_SAT_EN selects a signed saturating add instead of wrapping.
module psum_lane_add
    import psum_acc_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF
) (
    input  logic signed [PSUM_W-1:0] a,
    input  logic signed [PSUM_W-1:0] b,
    input  logic                     first_pass,
    output logic signed [PSUM_W-1:0] sum
);

`ifdef PSUM_ACC_SAT_EN
    localparam logic signed [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    // One guard bit: overflow shows up as disagreement between the top two bits.
    function automatic logic signed [PSUM_W-1:0] lane_add(
        input logic signed [PSUM_W-1:0] x,
        input logic signed [PSUM_W-1:0] y
    );
        logic [PSUM_W:0] ext;
        ext = {x[PSUM_W-1], x} + {y[PSUM_W-1], y};
        if (ext[PSUM_W] != ext[PSUM_W-1])
            return ext[PSUM_W] ? SAT_MIN : SAT_MAX;
        return ext[PSUM_W-1:0];
    endfunction
`else
    function automatic logic signed [PSUM_W-1:0] lane_add(
        input logic signed [PSUM_W-1:0] x,
        input logic signed [PSUM_W-1:0] y
    );
        return x + y;
    endfunction
`endif

    assign sum = first_pass ? b : lane_add(a, b);

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates systolic-array psum rows over several weight-tile passes, then drains them.
// Build macro PSUM_ACC_SAT_EN makes the per-lane accumulation saturate.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int ARRAY_SIZE = 8,
    parameter int ACC_DEPTH  = 16,
    parameter int PSUM_W     = PSUM_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [$clog2(ACC_DEPTH+1)-1:0]      cfg_rows,
    input  logic [7:0]                          cfg_passes,
    output logic                                busy,
    input  logic                                in_valid,
    input  logic [ARRAY_SIZE-1:0][PSUM_W-1:0]   psums,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ARRAY_SIZE-1:0][PSUM_W-1:0]   out_data,
    output logic                                out_last,
    output logic                                done
);

    localparam int CNT_W = $clog2(ACC_DEPTH + 1);
    localparam int PTR_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    typedef logic [ARRAY_SIZE-1:0][PSUM_W-1:0] row_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] row_ptr, drain_ptr, drain_nxt, rows_last;
    logic [7:0]       pass_cnt, passes_last;
    logic             done_d;
    logic             start_ok, acc_we, row_end, final_wr, first_pass;
    row_t             mem [ACC_DEPTH];
    row_t             cur_row, sum_row;

    assign start_ok   = (cfg_rows != '0) && (cfg_rows <= CNT_W'(ACC_DEPTH)) && (cfg_passes != 8'd0);
    assign acc_we     = (state_q == ACCUM) && in_valid;
    assign row_end    = (row_ptr == rows_last);
    assign final_wr   = acc_we && row_end && (pass_cnt == passes_last);
    assign first_pass = (pass_cnt == 8'd0);
    assign drain_nxt  = drain_ptr + PTR_W'(1);
    assign cur_row    = mem[row_ptr];

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DRAIN);

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        psum_lane_add #(.PSUM_W(PSUM_W)) u_add (
            .a          (cur_row[i]),
            .b          (psums[i]),
            .first_pass (first_pass),
            .sum        (sum_row[i])
        );
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) state_d = ACCUM;
                    else          done_d  = 1'b1;
                end
            end
            ACCUM: begin
                if (final_wr) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; the row buffer itself is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_ptr     <= '0;
            drain_ptr   <= '0;
            rows_last   <= '0;
            pass_cnt    <= '0;
            passes_last <= '0;
            out_last    <= 1'b0;
            out_data    <= '0;
            done        <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            case (state_q)
                IDLE: begin
                    if (start && start_ok) begin
                        rows_last   <= PTR_W'(cfg_rows - CNT_W'(1));
                        passes_last <= cfg_passes - 8'd1;
                        row_ptr     <= '0;
                        pass_cnt    <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (row_end) begin
                            row_ptr  <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                        end else begin
                            row_ptr <= row_ptr + PTR_W'(1);
                        end
                        // Row 0 is final already unless it is the very row being written now.
                        if (final_wr) begin
                            drain_ptr <= '0;
                            out_last  <= (rows_last == '0);
                            out_data  <= (rows_last == '0) ? sum_row : mem[0];
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_last <= 1'b0;
                        end else begin
                            drain_ptr <= drain_nxt;
                            out_data  <= mem[drain_nxt];
                            out_last  <= (drain_nxt == rows_last);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && acc_we) mem[row_ptr] <= sum_row;
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator; expected values are hand-computed per step.
module tb_psum_accumulator;

    localparam int ARRAY_SIZE = 8;
    localparam int ACC_DEPTH  = 16;
    localparam int PSUM_W     = 32;

    typedef logic [ARRAY_SIZE-1:0][PSUM_W-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_rows;
    logic [7:0]  cfg_passes;
    logic        busy;
    logic        in_valid;
    row_t        psums;
    logic        out_valid;
    logic        out_ready;
    row_t        out_data;
    logic        out_last;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    psum_accumulator #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ACC_DEPTH  (ACC_DEPTH),
        .PSUM_W     (PSUM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_rows   (cfg_rows),
        .cfg_passes (cfg_passes),
        .busy       (busy),
        .in_valid   (in_valid),
        .psums      (psums),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic row_t all_v(input logic [31:0] val);
        row_t r;
        for (int i = 0; i < ARRAY_SIZE; i++) r[i] = val;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_job(input logic [4:0] rows, input logic [7:0] passes);
        start      = 1'b1;
        cfg_rows   = rows;
        cfg_passes = passes;
        tick();
        start = 1'b0;
    endtask

    task automatic send_row(input row_t r);
        in_valid = 1'b1;
        psums    = r;
        tick();
        in_valid = 1'b0;
    endtask

    row_t v, exp_row;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_rows   = '0;
        cfg_passes = '0;
        in_valid   = 1'b0;
        psums      = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        tick();

        // rows=2, passes=1
        start_job(5'd2, 8'd1);
        chk("t1_busy", busy, 1);
        send_row(all_v(32'd5));
        send_row(all_v(32'd7));
        chk("t1_valid0", out_valid, 1);
        chk("t1_data0", out_data, all_v(32'd5));
        chk("t1_last0", out_last, 0);
        out_ready = 1'b1;
        tick();
        chk("t1_data1", out_data, all_v(32'd7));
        chk("t1_last1", out_last, 1);
        tick();
        out_ready = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_valid_end", out_valid, 0);
        chk("t1_busy_end", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // rows=1, passes=3, with an input gap
        start_job(5'd1, 8'd3);
        v = '0; v[0] = 32'd10; send_row(v);
        tick();
        v[0] = 32'd20; send_row(v);
        v[0] = 32'd30; send_row(v);
        exp_row = '0; exp_row[0] = 32'd60;
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, exp_row);
        chk("t2_last", out_last, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_valid_end", out_valid, 0);

        // rows=4, passes=2, backpressure 1,0,0,1, and start while busy
        start_job(5'd4, 8'd2);
        send_row(all_v(32'd1));
        start = 1'b1; cfg_rows = 5'd1; cfg_passes = 8'd0;
        send_row(all_v(32'd2));
        start = 1'b0;
        chk("t3_start_busy_done", done, 0);
        chk("t3_start_busy_busy", busy, 1);
        send_row(all_v(32'd3));
        send_row(all_v(32'd4));
        send_row(all_v(32'd100));
        send_row(all_v(32'd200));
        send_row(all_v(32'd300));
        chk("t3_not_yet_valid", out_valid, 0);
        send_row(all_v(32'd400));
        chk("t3_data0", out_data, all_v(32'd101));
        chk("t3_last0", out_last, 0);
        out_ready = 1'b1; tick();
        chk("t3_data1", out_data, all_v(32'd202));
        out_ready = 1'b0; tick();
        chk("t3_hold1a", out_data, all_v(32'd202));
        tick();
        chk("t3_hold1b", out_data, all_v(32'd202));
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_last", out_last, 0);
        out_ready = 1'b1; tick();
        chk("t3_data2", out_data, all_v(32'd303));
        chk("t3_last2", out_last, 0);
        tick();
        chk("t3_data3", out_data, all_v(32'd404));
        chk("t3_last3", out_last, 1);
        tick();
        out_ready = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_valid_end", out_valid, 0);

        // overflow handling: lane0 +max+1, lane1 min+(-1), lane2 5+(-3)
        start_job(5'd1, 8'd2);
        v = '0; v[0] = 32'h7FFF_FFFF; v[1] = 32'h8000_0000; v[2] = 32'd5;
        send_row(v);
        v = '0; v[0] = 32'd1; v[1] = 32'hFFFF_FFFF; v[2] = 32'hFFFF_FFFD;
        send_row(v);
        exp_row = '0;
`ifdef PSUM_ACC_SAT_EN
        exp_row[0] = 32'h7FFF_FFFF; exp_row[1] = 32'h8000_0000;
`else
        exp_row[0] = 32'h8000_0000; exp_row[1] = 32'h7FFF_FFFF;
`endif
        exp_row[2] = 32'd2;
        chk("t4_lane0", out_data[0], exp_row[0]);
        chk("t4_lane1", out_data[1], exp_row[1]);
        chk("t4_row", out_data, exp_row);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("t4_done", done, 1);

        // invalid configurations
        tick();
        start_job(5'd2, 8'd0);
        chk("t5_p0_done", done, 1);
        chk("t5_p0_busy", busy, 0);
        tick();
        chk("t5_p0_done_pulse", done, 0);
        chk("t5_p0_valid", out_valid, 0);
        start_job(5'd17, 8'd1);
        chk("t5_r17_done", done, 1);
        chk("t5_r17_busy", busy, 0);

        // reset mid-ACCUM, then a fresh job sees new data
        start_job(5'd2, 8'd1);
        send_row(all_v(32'd9));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_last", out_last, 0);
        start_job(5'd1, 8'd1);
        send_row(all_v(32'd3));
        chk("t6_new_data", out_data, all_v(32'd3));
        chk("t6_new_last", out_last, 1);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("t6_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
Downstream stage of the 8x8 fusion-unit systolic array. Captures one row of column partial sums per cycle from the array's registered psums output. Accumulates those rows across multiple weight-tile passes into an on-block register buffer. Once the last pass completes, drains the finished rows to the output writer over a valid/ready interface.

Parameters:
ARRAY_SIZE, 8, number of array columns (psum lanes per row)
ACC_DEPTH, 16, number of output rows buffered per job
PSUM_W, 32, width of one psum lane (two's complement)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle job start pulse, sampled only in IDLE
cfg_rows  input  $clog2(ACC_DEPTH+1)  rows per pass, valid 1..ACC_DEPTH
cfg_passes  input  8  passes per job, valid 1..255
busy  output  1  high in ACCUM or DRAIN
in_valid  input  1  psums carries a valid row this cycle
psums  input  [ARRAY_SIZE-1:0][PSUM_W-1:0]  psum row from the array
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts
out_data  output  [ARRAY_SIZE-1:0][PSUM_W-1:0]  accumulated row
out_last  output  1  high with the final drained row
done  output  1  one-cycle pulse at job completion

Behaviour:
- Reset: state=IDLE; busy, out_valid, out_last, done = 0; out_data = 0; pointers and pass counter = 0. Buffer contents are not cleared; pass 0 overwrites them.
- Reset asserted mid-job aborts the job immediately, with no done pulse.
- FSM IDLE:
  - start with cfg_rows in 1..ACC_DEPTH and cfg_passes >= 1: latch cfg, go to ACCUM.
  - start with cfg_rows==0, cfg_rows>ACC_DEPTH, or cfg_passes==0: pulse done next cycle and stay IDLE.
- FSM ACCUM:
  - Each cycle with in_valid, entry mem[row_ptr] is written:
    - psums when pass==0;
    - mem[row_ptr]+psums lane-wise when pass>0, per-lane PSUM_W-bit wrapping add.
  - row_ptr increments. At cfg_rows-1, row_ptr wraps to 0 and pass increments.
  - On the write for row cfg_rows-1 of pass cfg_passes-1, go to DRAIN with drain_ptr=0.
  - in_valid gaps are allowed; no backpressure toward the array.
- FSM DRAIN:
  - out_valid=1; out_data=mem[drain_ptr], registered so it is valid the first DRAIN cycle.
  - out_last=1 when drain_ptr==cfg_rows-1.
  - On out_valid&&out_ready, drain_ptr increments and the next row is presented next cycle.
  - out_data and out_last hold stable while out_ready is low.
  - Handshake on the last row: go to IDLE, out_valid=0, done=1 for one cycle.
- Ignored inputs: in_valid outside ACCUM; start while busy.
- Latency: in_valid row to buffer update, 1 cycle. Final accumulate write to first out_valid, 1 cycle.
- Throughput: 1 row/cycle in both directions.

Optional Feature:
PSUM_ACC_SAT_EN
- Defined: lane add is signed saturating. Overflow clamps to 2^(PSUM_W-1)-1, underflow to -2^(PSUM_W-1).
- Not defined: wrapping modulo 2^PSUM_W.
- Pass 0 is unaffected either way.

Decomposition:
- Package psum_acc_pkg holds:
  - state enum {IDLE, ACCUM, DRAIN};
  - PSUM_W default;
  - signed min/max localparams for saturation.
- Sub-module psum_lane_add: one lane, inputs a, b, first_pass, output sum. Contains the wrap/saturate logic under PSUM_ACC_SAT_EN. Instantiated ARRAY_SIZE times.

Test Plan:
- rows=2, passes=1; psums rows all 5, then all 7 -> drain outputs 5s then 7s, out_last on row 2, done 1 cycle after.
- rows=1, passes=3; lane0 = 10, 20, 30 -> drained lane0 = 60, single beat with out_last=1.
- rows=4, passes=2; out_ready toggled 1,0,0,1 -> each out_data held stable while ready low; 4 beats in order; no loss or duplication.
- Wrap vs saturation: rows=1, passes=2; lane0 = 0x7FFFFFFF then 1 -> 0x80000000 without PSUM_ACC_SAT_EN, 0x7FFFFFFF with it. Likewise 0x80000000 + (-1) saturates to 0x80000000.
- start with cfg_passes=0 -> done pulse, busy stays 0, out_valid never rises. start pulsed while busy -> no effect.
- rst asserted mid-ACCUM -> next cycle IDLE, all outputs 0. A new job with rows=1, passes=1 then returns the new psums, not stale sums.
